// File: rtl/ieee2fp_5_5_if.sv
// Stream handshake bundle for ieee2fp_5_5: 11-bit IEEE-style input side, 13-bit FloPoCo output side.
interface ieee2fp_5_5_if;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );
endinterface

// File: rtl/ieee2fp_5_5.sv
// ieee2fp_5_5: two-stage IEEE-style (1/5/5, bias 15) to FloPoCo converter with sticky NaN flag and flush counter.
// Optional macro SUBNORMAL_NORM_EN: subnormals with fraction[4]=1 are renormalised instead of flushed to zero.
module ieee2fp_5_5 #(
  parameter int ID = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  ieee2fp_5_5_if.slave  bus,
  input  logic          clear_flags,
  output logic          nan_seen,
  output logic [7:0]    flush_cnt
);

  typedef enum logic [2:0] {
    CLS_ZERO   = 3'd0,
    CLS_SUB    = 3'd1,
    CLS_NORMAL = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NAN    = 3'd4
  } cls_e;

  function automatic cls_e classify(input logic [4:0] exp, input logic [4:0] frac);
    cls_e cls;
    if (exp == 5'd31) begin
      cls = (frac != 5'd0) ? CLS_NAN : CLS_INF;
    end else if (exp == 5'd0) begin
      cls = (frac != 5'd0) ? CLS_SUB : CLS_ZERO;
    end else begin
      cls = CLS_NORMAL;
    end
    return cls;
  endfunction

  // A subnormal that ends up with exc=00 is a flush; renormalised ones are not.
  function automatic logic is_flush(input logic [9:0] mag);
    logic flush;
    flush = (mag[9:5] == 5'd0) && (mag[4:0] != 5'd0);
`ifdef SUBNORMAL_NORM_EN
    flush = flush && !mag[4];
`endif
    return flush;
  endfunction

  function automatic logic [12:0] assemble(input logic sign, input cls_e cls,
                                           input logic [4:0] exp, input logic [4:0] frac);
    logic [12:0] res;
    res = 13'd0;
    case (cls)
      CLS_NORMAL: res = {2'b01, sign, exp, frac};
      CLS_INF:    res = {2'b10, sign, 10'd0};
      CLS_NAN:    res = {2'b11, 1'b0, 10'd0};
      CLS_ZERO:   res = {2'b00, sign, 10'd0};
      CLS_SUB: begin
`ifdef SUBNORMAL_NORM_EN
        if (frac[4]) begin
          res = {2'b01, sign, 5'd0, frac[3:0], 1'b0};
        end else begin
          res = {2'b00, sign, 10'd0};
        end
`else
        res = {2'b00, sign, 10'd0};
`endif
      end
      default:    res = 13'd0;
    endcase
    return res;
  endfunction

  logic        s1_valid_r;
  logic        s1_sign_r;
  cls_e        s1_cls_r;
  logic [4:0]  s1_exp_r;
  logic [4:0]  s1_frac_r;
  logic        s2_valid_r;
  logic [12:0] s2_data_r;
  logic        nan_seen_r;
  logic [7:0]  flush_cnt_r;

  logic        s2_adv_s;
  logic        s1_adv_s;
  logic        in_ready_s;
  logic        in_fire_s;
  cls_e        in_cls_s;
  logic        nan_evt_s;
  logic        flush_evt_s;
  logic [12:0] s1_asm_s;

  // Pipeline advance, input acceptance, capture-time events and S2 assembly.
  always_comb begin
    s2_adv_s    = !s2_valid_r || bus.out_ready;
    s1_adv_s    = !s1_valid_r || s2_adv_s;
    in_ready_s  = rst_n && s1_adv_s;
    in_fire_s   = bus.in_valid && in_ready_s;
    in_cls_s    = classify(bus.in_data[9:5], bus.in_data[4:0]);
    nan_evt_s   = in_fire_s && (in_cls_s == CLS_NAN);
    flush_evt_s = in_fire_s && is_flush(bus.in_data[9:0]);
    s1_asm_s    = assemble(s1_sign_r, s1_cls_r, s1_exp_r, s1_frac_r);
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = s2_valid_r;
  assign bus.out_data  = s2_data_r;
  assign nan_seen      = nan_seen_r;
  assign flush_cnt     = flush_cnt_r;

  // Stage 1: sign, class and raw fields of the accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_sign_r  <= 1'b0;
      s1_cls_r   <= CLS_ZERO;
      s1_exp_r   <= 5'd0;
      s1_frac_r  <= 5'd0;
    end else if (s1_adv_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_sign_r <= bus.in_data[10];
        s1_cls_r  <= in_cls_s;
        s1_exp_r  <= bus.in_data[9:5];
        s1_frac_r <= bus.in_data[4:0];
      end
    end
  end

  // Stage 2: assembled FloPoCo word; holds while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= 13'd0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_data_r <= s1_asm_s;
      end
    end
  end

  // Sticky NaN flag and saturating flush counter; clear wins over a coincident event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nan_seen_r  <= 1'b0;
      flush_cnt_r <= 8'd0;
    end else if (clear_flags) begin
      nan_seen_r  <= 1'b0;
      flush_cnt_r <= 8'd0;
    end else begin
      if (nan_evt_s) begin
        nan_seen_r <= 1'b1;
      end
      if (flush_evt_s && (flush_cnt_r != 8'hFF)) begin
        flush_cnt_r <= flush_cnt_r + 8'd1;
      end
    end
  end

  if (ID >= 0) begin : g_chk
    ieee2fp_5_5_chk u_chk (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_ready    (in_ready_s),
      .out_valid   (s2_valid_r),
      .out_ready   (bus.out_ready),
      .out_data    (s2_data_r),
      .s1_valid    (s1_valid_r),
      .clear_flags (clear_flags),
      .nan_seen    (nan_seen_r),
      .flush_cnt   (flush_cnt_r)
    );
  end

endmodule

// Protocol and flag invariants of ieee2fp_5_5.
module ieee2fp_5_5_chk (
  input logic        clk,
  input logic        rst_n,
  input logic        in_ready,
  input logic        out_valid,
  input logic        out_ready,
  input logic [12:0] out_data,
  input logic        s1_valid,
  input logic        clear_flags,
  input logic        nan_seen,
  input logic [7:0]  flush_cnt
);

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));

  a_ready_only_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !in_ready |-> (s1_valid && out_valid && !out_ready));

  a_nan_sticky: assert property (@(posedge clk) disable iff (!rst_n)
    (nan_seen && !clear_flags) |=> nan_seen);

  a_cnt_saturates: assert property (@(posedge clk) disable iff (!rst_n)
    ((flush_cnt == 8'hFF) && !clear_flags) |=> (flush_cnt == 8'hFF));

endmodule

// File: tb/tb_ieee2fp_5_5.sv
// Scoreboard bench for ieee2fp_5_5: expected words queued on input acceptance, compared on output transfer.
module tb_ieee2fp_5_5;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_flags = 1'b0;
  logic       nan_seen;
  logic [7:0] flush_cnt;

  ieee2fp_5_5_if bus();

  ieee2fp_5_5 #(.ID(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .clear_flags (clear_flags),
    .nan_seen    (nan_seen),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [12:0] exp_q[$];
  int          occ = 0;
  logic        m_nan = 1'b0;
  int          m_cnt = 0;
  logic        hold_prev = 1'b0;
  logic [12:0] prev_data = 13'd0;
  logic        rand_mode = 1'b0;
  logic        or_fixed = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] model(input logic [10:0] v);
    logic       s;
    logic [4:0] e;
    logic [4:0] f;
    s = v[10];
    e = v[9:5];
    f = v[4:0];
    if (e == 5'd31) return (f != 5'd0) ? 13'h1800 : (s ? 13'h1400 : 13'h1000);
    if (e != 5'd0) return {2'b01, v};
    if (f == 5'd0) return s ? 13'h0400 : 13'h0000;
`ifdef SUBNORMAL_NORM_EN
    if (f[4]) return 13'h0800 | (s ? 13'h0400 : 13'h0000) | {8'd0, f[3:0], 1'b0};
`endif
    return s ? 13'h0400 : 13'h0000;
  endfunction

  function automatic bit model_flush(input logic [10:0] v);
    if (v[9:5] != 5'd0 || v[4:0] == 5'd0) return 1'b0;
`ifdef SUBNORMAL_NORM_EN
    if (v[4]) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // Consumer ready: random in stream phases, otherwise the value the main sequence asks for.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rand_mode ? 1'($urandom_range(0, 1)) : or_fixed;
    end
  end

  // Monitor / scoreboard, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        occ = 0;
        m_nan = 1'b0;
        m_cnt = 0;
        hold_prev = 1'b0;
      end else begin
        logic in_f;
        logic out_f;
        in_f  = bus.in_valid && bus.in_ready;
        out_f = bus.out_valid && bus.out_ready;
        check_val("in_ready", 32'(bus.in_ready), (occ == 2 && !bus.out_ready) ? 32'd0 : 32'd1);
        check_val("nan_seen", 32'(nan_seen), 32'(m_nan));
        check_val("flush_cnt", 32'(flush_cnt), 32'(m_cnt));
        if (hold_prev) begin
          check_val("hold_valid", 32'(bus.out_valid), 32'd1);
          check_val("hold_data", 32'(bus.out_data), 32'(prev_data));
        end
        if (out_f) begin
          if (exp_q.size() == 0) check_val("spurious_out", 32'(exp_q.size()), 32'd1);
          else check_val("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        if (in_f) exp_q.push_back(model(bus.in_data));
        if (clear_flags) begin
          m_nan = 1'b0;
          m_cnt = 0;
        end else if (in_f) begin
          if (bus.in_data[9:5] == 5'd31 && bus.in_data[4:0] != 5'd0) m_nan = 1'b1;
          if (model_flush(bus.in_data) && m_cnt < 255) m_cnt = m_cnt + 1;
        end
        occ = occ + int'(in_f) - int'(out_f);
        hold_prev = bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [10:0] v);
    int   budget;
    logic acc;
    budget = 0;
    acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = v;
    while (!acc && budget < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    if (!acc) check_val("send_timeout", 32'(acc), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [10:0] dir_vals[10];
    int          cnt_before;
    int          budget;
    dir_vals = '{11'h000, 11'h400, 11'h3E0, 11'h7FF, 11'h41F,
                 11'h3DF, 11'h020, 11'h010, 11'h810, 11'h5A5};
    bus.in_valid = 1'b0;
    bus.in_data  = 11'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_data", 32'(bus.out_data), 32'd0);
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("rst_nan", 32'(nan_seen), 32'd0);
    check_val("rst_cnt", 32'(flush_cnt), 32'd0);
    rst_n = 1'b1;
    #1;
    check_val("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    idle(1);

    // +1.0 latency
    send(11'h1E0);
    check_val("lat_c1_valid", 32'(bus.out_valid), 32'd0);
    idle(1);
    check_val("lat_c2_valid", 32'(bus.out_valid), 32'd1);
    check_val("lat_c2_data", 32'(bus.out_data), 32'h09E0);
    idle(2);

    // -inf, NaN and sticky flag
    send(11'h7E0);
    send(11'h7E1);
    idle(4);
    check_val("nan_set", 32'(nan_seen), 32'd1);
    idle(3);
    check_val("nan_sticky", 32'(nan_seen), 32'd1);
    clear_flags = 1'b1;
    idle(1);
    clear_flags = 1'b0;
    check_val("nan_cleared", 32'(nan_seen), 32'd0);

    // Subnormal 0x010
    cnt_before = int'(flush_cnt);
    send(11'h010);
    idle(3);
`ifdef SUBNORMAL_NORM_EN
    check_val("sub_cnt", 32'(flush_cnt), 32'(cnt_before));
`else
    check_val("sub_cnt", 32'(flush_cnt), 32'(cnt_before + 1));
`endif

    // Directed class mix
    foreach (dir_vals[i]) send(dir_vals[i]);
    idle(4);

    // Counter saturation, then clear coinciding with a flush
    for (int i = 0; i < 300; i++) send(11'h00F);
    idle(3);
    check_val("cnt_sat", 32'(flush_cnt), 32'd255);
    clear_flags = 1'b1;
    send(11'h00F);
    clear_flags = 1'b0;
    idle(2);
    check_val("cnt_clear_wins", 32'(flush_cnt), 32'd0);

    // Directed stall with both stages full
    or_fixed = 1'b0;
    idle(1);
    send(11'h2AB);
    send(11'h0C3);
    idle(4);
    check_val("full_in_ready", 32'(bus.in_ready), 32'd0);
    or_fixed = 1'b1;
    idle(4);

    // Random stream with random backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 10; i++) send(11'($urandom_range(0, 2047)));
    for (int i = 0; i < 10; i++) send(dir_vals[i] ^ 11'($urandom_range(0, 1)));
    rand_mode = 1'b0;
    or_fixed = 1'b1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      idle(1);
      budget++;
    end
    check_val("drain", 32'(exp_q.size()), 32'd0);

    // Reset with two values in flight
    or_fixed = 1'b0;
    idle(1);
    send(11'h1E0);
    send(11'h7E1);
    idle(1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check_val("midrst_nan", 32'(nan_seen), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    or_fixed = 1'b1;
    idle(5);
    check_val("no_stale_out", 32'(bus.out_valid), 32'd0);
    send(11'h3E0);
    idle(3);
    check_val("post_rst_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
